// File: rtl/sevenseg_scan_ctrl.sv
// Purpose     : time-multiplexed seven-segment scan controller with a double-buffered hex load port.
// Latency     : outputs trail the scan state by one register; a loaded value reaches the pads at the next frame boundary.
// Backpressure: load_ready_o stays low while a loaded value waits for its commit, which can take up to one frame.
//
// Optional feature macro: SEVENSEG_LZB_EN (leading-zero blanking). When it is undefined, every digit is decoded.
//
// Ports
//   wb_clk_i      sole clock, rising edge
//   wb_rst_ni     synchronous active-low reset
//   enable_i      scan enable; low parks the scanner in IDLE with the pads tri-stated
//   value_i       hex nibbles, nibble 0 = rightmost digit
//   dp_i          decimal points, captured together with value_i
//   load_valid_i  load request
//   load_ready_o  shadow buffer free
//   seg_o         segments a..g on bits 0..6, active-high
//   dp_o          decimal point, active-high
//   dig_o         one-hot digit enable, active-high
//   oeb_o         pad output-enable bar, ordered {dig, dp, seg}
//   frame_o       one-cycle pulse at the first blank slot of digit 0 after a wrap
//
// Parameters: NUM_DIGITS 1..8, PRESCALE >= 1, BLANK_CYCLES >= 1.

module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      enable_i,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     dig_o,
    output logic [8+NUM_DIGITS-1:0]   oeb_o,
    output logic                      frame_o
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int OEB_W   = 8 + NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_wrap;        // state register just crossed a frame boundary

    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    // Inverse of the pending flag, kept in this polarity so load_ready_o comes straight off a flop.
    logic                    r_ready;

    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic [OEB_W-1:0]        r_oeb;
    logic                    r_frame;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_wrap;
    logic                    w_accept;

    assign w_accept = load_valid_i && r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        if (!enable_i) begin
            // Disable parks the scanner from any state; the buffers are left alone.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = BLANK_LOAD;
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = ON_LOAD;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                        // Explicit wrap so non-power-of-two digit counts work.
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit select and decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_blank_dig;
    logic [6:0]              w_seg_dec;

    // Equality-compare mux keeps the index inside the digit range for any NUM_DIGITS.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_onehot = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_nib       = r_disp_val[4*d +: 4];
                w_dp_sel    = r_disp_dp[d];
                w_onehot[d] = 1'b1;
            end
        end
    end

`ifdef SEVENSEG_LZB_EN
    // w_zero_from[d] is set when nibbles d and everything above it are all zero.
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic                    w_zero_sel;

    always_comb begin
        logic w_acc;
        w_acc       = 1'b1;
        w_zero_from = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_acc          = w_acc && (r_disp_val[4*d +: 4] == 4'h0);
            w_zero_from[d] = w_acc;
        end
    end

    always_comb begin
        w_zero_sel = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_zero_sel = w_zero_from[d];
            end
        end
    end

    // Digit 0 is never blanked, so an all-zero value still shows "0".
    assign w_blank_dig = (r_idx != '0) && w_zero_sel;
`else
    assign w_blank_dig = 1'b0;
`endif

    assign w_seg_dec = w_blank_dig ? 7'h00 : hex7(w_nib);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_wrap       <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_ready      <= 1'b1;
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_dig        <= '0;
            r_oeb        <= '1;
            r_frame      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_wrap  <= w_wrap;

            // Commit uses the pending state from before this edge, so a load accepted
            // on the boundary edge itself waits for the following boundary.
            if (w_wrap && !r_ready) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
            end
            if (w_accept) begin
                r_shadow_val <= value_i;
                r_shadow_dp  <= dp_i;
                r_ready      <= 1'b0;
            end else if (w_wrap) begin
                r_ready      <= 1'b1;
            end

            // Pad outputs are a registered view of the current scan state.
            case (r_state)
                ST_BLANK: begin
                    r_seg <= w_seg_dec;
                    r_dp  <= w_dp_sel;
                    r_dig <= '0;
                    r_oeb <= '0;
                end
                ST_ON: begin
                    r_seg <= w_seg_dec;
                    r_dp  <= w_dp_sel;
                    r_dig <= w_onehot;
                    r_oeb <= '0;
                end
                default: begin
                    r_seg <= '0;
                    r_dp  <= 1'b0;
                    r_dig <= '0;
                    r_oeb <= '1;
                end
            endcase
            r_frame <= r_wrap;
        end
    end

    assign load_ready_o = r_ready;
    assign seg_o        = r_seg;
    assign dp_o         = r_dp;
    assign dig_o        = r_dig;
    assign oeb_o        = r_oeb;
    assign frame_o      = r_frame;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
module tb_sevenseg_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int B  = 2;
    localparam int DL = B + P;      // clocks per digit slot
    localparam int F  = N * DL;     // frame period

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           en;
    logic           lv;
    logic [4*N-1:0] val;
    logic [N-1:0]   dpi;

    logic           load_ready_o;
    logic [6:0]     seg_o;
    logic           dp_o;
    logic [N-1:0]   dig_o;
    logic [8+N-1:0] oeb_o;
    logic           frame_o;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .enable_i     (en),
        .value_i      (val),
        .dp_i         (dpi),
        .load_valid_i (lv),
        .load_ready_o (load_ready_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .dig_o        (dig_o),
        .oeb_o        (oeb_o),
        .frame_o      (frame_o)
    );

    typedef struct packed {
        logic [6:0]     seg;
        logic           dp;
        logic [N-1:0]   dig;
        logic [8+N-1:0] oeb;
        logic           frame;
        logic           rdy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // ------------------------------------------------------------------
    // Reference model: scan position counted in clocks since the scan started.
    // ------------------------------------------------------------------
    bit             m_run;
    int             m_pos;
    bit             m_pend;
    logic [4*N-1:0] m_sh_v, m_di_v;
    logic [N-1:0]   m_sh_dp, m_di_dp;

    function automatic obs_t view();
        obs_t e;
        int   d;
        logic [3:0] nib;
        e = '0;
        if (!m_run) begin
            e.oeb = '1;
        end else begin
            d      = (m_pos / DL) % N;
            nib    = m_di_v[4*d +: 4];
            e.seg  = seg_tab[nib];
`ifdef SEVENSEG_LZB_EN
            if (d != 0 && (m_di_v >> (4*d)) == '0) e.seg = 7'h00;
`endif
            e.dp    = m_di_dp[d];
            e.dig   = ((m_pos % DL) >= B) ? N'(1 << d) : '0;
            e.oeb   = '0;
            e.frame = (m_pos > 0) && (m_pos % F == 0);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        obs_t e;
        bit   acc;
        bit   wrap;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_pend = 0;
            m_sh_v = '0; m_di_v = '0; m_sh_dp = '0; m_di_dp = '0;
            e = '0;
            e.oeb = '1;
            e.rdy = 1'b1;
        end else begin
            e    = view();
            acc  = lv && !m_pend;
            wrap = 0;
            if (!en) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0;
            end else begin
                m_pos++;
                wrap = (m_pos % F == 0);
            end
            if (wrap && m_pend) begin
                m_di_v = m_sh_v; m_di_dp = m_sh_dp; m_pend = 0;
            end
            if (acc) begin
                m_sh_v = val; m_sh_dp = dpi; m_pend = 1;
            end
            e.rdy = !m_pend;
        end
        exp_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        obs_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {seg_o, dp_o, dig_o, oeb_o, frame_o, load_ready_o};
            checks++;
            if (a === e) passed++;
            else $display("FAIL outputs cyc=%0d got seg=%h dp=%b dig=%b oeb=%h frame=%b rdy=%b want seg=%h dp=%b dig=%b oeb=%h frame=%b rdy=%b",
                          cyc, a.seg, a.dp, a.dig, a.oeb, a.frame, a.rdy,
                          e.seg, e.dp, e.dig, e.oeb, e.frame, e.rdy);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic logic [4*N-1:0] rand_val();
        logic [4*N-1:0] v;
        int keep;
        v    = 16'($urandom);
        keep = $urandom_range(0, N);
        v    = v & (16'hFFFF >> (4*(N - keep)));
        return v;
    endfunction

    task automatic wait_dig(input int d, output bit ok);
        ok = 0;
        for (int i = 0; i < 3*F; i++) begin
            @(negedge clk);
            if (dig_o == N'(1 << d)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_frame_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 3*F; i++) begin
            @(negedge clk);
            if (frame_o && load_ready_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic load_once(input logic [4*N-1:0] v, input logic [N-1:0] d);
        lv = 1; val = v; dpi = d;
        @(negedge clk);
        lv = 0;
    endtask

    initial begin
        bit ok;
        rst_n = 0; en = 1; lv = 0; val = '0; dpi = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Scan sequence with 0x1234
        load_once(16'h1234, 4'b0001);
        repeat (3*F) @(negedge clk);

        // Double buffer: 0xAAAA then 0x5555 held against backpressure
        lv = 1; val = 16'hAAAA; dpi = 4'b1000;
        @(negedge clk);
        val = 16'h5555; dpi = 4'b0010;
        repeat (2*F + 4) @(negedge clk);
        lv = 0;
        repeat (F) @(negedge clk);

        // Mid-scan disable during digit 2 with a load pending
        load_once(16'h0007, 4'b0000);
        wait_dig(2, ok);
        if (!ok) begin
            checks++;
            $display("FAIL dig2_wait got dig=%b want %b within %0d cycles", dig_o, 4'b0100, 3*F);
        end
        en = 0;
        repeat (3) @(negedge clk);
        en = 1;
        repeat (2*F) @(negedge clk);

        // Loads presented on the frame_o cycle
        for (int k = 0; k < 3; k++) begin
            wait_frame_ready(ok);
            if (!ok) begin
                checks++;
                $display("FAIL frame_wait got frame=%b rdy=%b want 1/1 within %0d cycles", frame_o, load_ready_o, 3*F);
            end
            load_once(rand_val(), N'($urandom));
            repeat (F + 3) @(negedge clk);
        end

        // Leading-zero cases
        load_once(16'h0000, 4'b0100);
        repeat (2*F) @(negedge clk);
        load_once(16'h0070, 4'b0000);
        repeat (2*F) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 39) != 0);
            lv  = ($urandom_range(0, 3) == 0);
            val = rand_val();
            dpi = N'($urandom);
            @(negedge clk);
        end
        en = 1; lv = 0;

        // Reset in the middle of a scan
        repeat (F/2) @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        load_once(16'hC0DE, 4'b1010);
        repeat (2*F + 2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
